// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin arbiter sharing one ALU between two requesters.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arb #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [4:0]  req_shamt0,
  input  logic [4:0]  req_shamt1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_of,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_of,
  output logic        busy
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b100;

  // Counter holds remaining EXEC cycles minus one, so 0 marks the last cycle.
  localparam logic [3:0] c_MUL_WAIT = 4'(MUL_LAT - 1);

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [3:0]  r_wait;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_sel;
  logic [4:0]  r_alu_shamt;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_result;
  logic        r_rsp_of;

  logic        w_gnt;
  logic        w_hs;
  logic [2:0]  w_op;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt = 1'b0;
    if (req_valid == 2'b11) w_gnt = ~r_last_grant;
    else                    w_gnt = req_valid[1];
  end

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (r_state == c_ST_IDLE))
      req_ready = (w_gnt ? 2'b10 : 2'b01) & req_valid;
  end

  assign w_hs = |(req_valid & req_ready);
  assign w_op = w_gnt ? req_op1 : req_op0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_wait       <= 4'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_sel    <= 3'd0;
      r_alu_shamt  <= 5'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_of     <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_hs) begin
            r_alu_a      <= w_gnt ? req_a1 : req_a0;
            r_alu_b      <= w_gnt ? req_b1 : req_b0;
            r_alu_sel    <= w_op;
            r_alu_shamt  <= w_gnt ? req_shamt1 : req_shamt0;
            r_owner      <= w_gnt;
            r_last_grant <= w_gnt;
            r_wait       <= (w_op == c_OP_MUL) ? c_MUL_WAIT : 4'd0;
            r_state      <= c_ST_EXEC;
          end
        end
        c_ST_EXEC: begin
          if (r_wait == 4'd0) begin
            r_rsp_result <= alu_result;
            // Overflow is only meaningful for add and subtract.
            r_rsp_of     <= alu_of & ((r_alu_sel == c_OP_ADD) || (r_alu_sel == c_OP_SUB));
            r_rsp_id     <= r_owner;
            r_rsp_valid  <= 1'b1;
            r_state      <= c_ST_RESP;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        c_ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign alu_shamt  = r_alu_shamt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_of     = r_rsp_of;
  assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Directed self-checking bench for alu_share_arb with a simple ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_of;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_of, busy;
  logic [31:0] rsp_result;
  logic        of_force;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arb #(.MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_of(rsp_of), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 000 and, 010 add, 110 sub, 100 mul, 011 shift left.
  always_comb begin
    logic [31:0] s;
    s = 32'd0;
    alu_of = of_force;
    case (alu_sel)
      3'b000: s = alu_a & alu_b;
      3'b010: begin
        s = alu_a + alu_b;
        alu_of = of_force | ((alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]));
      end
      3'b110: begin
        s = alu_a - alu_b;
        alu_of = of_force | ((alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]));
      end
      3'b100: s = alu_a * alu_b;
      3'b011: s = alu_a << alu_shamt;
      default: s = 32'd0;
    endcase
    alu_result = s;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_and [2];
    exp_and[0] = 32'hF000_F000;
    exp_and[1] = 32'h0204_0608;

    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0; of_force = 1'b0;
    req_op0 = 3'b000; req_op1 = 3'b000;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    req_shamt0 = 5'd0; req_shamt1 = 5'd0;

    // Reset state, with both requests pending
    cyc(); cyc();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_sel", 32'(alu_sel), 32'h0);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    cyc();

    // Requester 0 add overflow
    req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 32'h7FFF_FFFF; req_b0 = 32'h1; rsp_ready = 1'b1;
    #1 chk("add_req_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    chk("add_exec_busy", 32'(busy), 32'h1);
    chk("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("add_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("add_alu_sel", 32'(alu_sel), 32'h2);
    cyc();
    chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("add_rsp_result", rsp_result, 32'h8000_0000);
    chk("add_rsp_of", 32'(rsp_of), 32'h1);
    chk("add_rsp_id", 32'(rsp_id), 32'h0);
    cyc();
    chk("add_done_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("add_done_busy", 32'(busy), 32'h0);
    chk("add_hold_alu_a", alu_a, 32'h7FFF_FFFF);

    // Round robin from a fresh reset: grants 0,1,0,1
    rst_n = 1'b0; #2 rst_n = 1'b1;
    cyc();
    req_op0 = 3'b000; req_a0 = 32'hF0F0_F0F0; req_b0 = 32'hFF00_FF00;
    req_op1 = 3'b000; req_a1 = 32'h1234_5678; req_b1 = 32'h0F0F_0F0F;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
      chk($sformatf("rr%0d_exec_ready", k), 32'(req_ready), 32'h0);
      cyc();
      chk($sformatf("rr%0d_resp_ready", k), 32'(req_ready), 32'h0);
      chk($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(k % 2));
      chk($sformatf("rr%0d_rsp_result", k), rsp_result, exp_and[k % 2]);
      chk($sformatf("rr%0d_rsp_of", k), 32'(rsp_of), 32'h0);
      cyc();
    end
    req_valid = 2'b00;

    // Requester 1 multiply, overflow input must be masked
    req_valid = 2'b10; req_op1 = 3'b100; req_a1 = 32'd3; req_b1 = 32'd5; of_force = 1'b1;
    #1 chk("mul_req_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    chk("mul_exec1_valid", 32'(rsp_valid), 32'h0);
    cyc();
    chk("mul_exec2_valid", 32'(rsp_valid), 32'h0);
    chk("mul_exec2_busy", 32'(busy), 32'h1);
    cyc();
    chk("mul_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("mul_rsp_result", rsp_result, 32'd15);
    chk("mul_rsp_of", 32'(rsp_of), 32'h0);
    chk("mul_rsp_id", 32'(rsp_id), 32'h1);
    cyc();
    of_force = 1'b0;

    // Shift with back-pressure; requester 1 kept valid throughout
    req_valid = 2'b11; req_op0 = 3'b011; req_a0 = 32'd1; req_shamt0 = 5'd31;
    req_op1 = 3'b000; rsp_ready = 1'b0;
    #1 chk("shl_req_ready", 32'(req_ready), 32'h1);
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("shl_hold%0d_valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("shl_hold%0d_result", k), rsp_result, 32'h8000_0000);
      chk($sformatf("shl_hold%0d_ready", k), 32'(req_ready), 32'h0);
      chk($sformatf("shl_hold%0d_shamt", k), 32'(alu_shamt), 32'd31);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("shl_release_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("shl_done_valid", 32'(rsp_valid), 32'h0);
    chk("shl_next_grant", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    #1 chk("shl_drop_ready", 32'(req_ready), 32'h0);

    // Reset during EXEC of a subtract
    req_valid = 2'b01; req_op0 = 3'b110; req_a0 = 32'd5; req_b0 = 32'd3;
    cyc();
    req_valid = 2'b00;
    chk("rexec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rexec_busy_async", 32'(busy), 32'h0);
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rexec_alu_sel", 32'(alu_sel), 32'h0);
    #1 rst_n = 1'b1;
    cyc();
    chk("rexec_post1_valid", 32'(rsp_valid), 32'h0);
    cyc();
    chk("rexec_post2_valid", 32'(rsp_valid), 32'h0);
    chk("rexec_post2_busy", 32'(busy), 32'h0);
    req_valid = 2'b11;
    #1 chk("rexec_tie_grant", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: MUL_LAT, 2, number of EXEC cycles allowed for ALU_sel=100 (multiply); legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 Port: req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 Port: req_op0 / req_op1  input  3 each  ALU_sel code of requester 0 / 1.
REQ-007 Port: req_a0, req_b0, req_a1, req_b1  input  32 each  operands of requester 0 / 1.
REQ-008 Port: req_shamt0 / req_shamt1  input  5 each  shift amount of requester 0 / 1.
REQ-009 Port: alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-010 Port: alu_sel  output  3  registered ALU_sel to the ALU.
REQ-011 Port: alu_shamt  output  5  registered shamt to the ALU.
REQ-012 Port: alu_result  input  32  ALU_result returned by the ALU.
REQ-013 Port: alu_of  input  1  OF returned by the ALU.
REQ-014 Port: rsp_valid  output  1  response available.
REQ-015 Port: rsp_ready  input  1  consumer accepts response.
REQ-016 Port: rsp_id  output  1  requester index that owns the response.
REQ-017 Port: rsp_result  output  32  captured ALU result.
REQ-018 Port: rsp_of  output  1  captured overflow, masked per REQ-027.
REQ-019 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-021 IDLE: if any req_valid bit set, SHALL grant one requester by round-robin: the requester not granted last wins when both are valid; a sole valid requester always wins.
REQ-022 req_ready[g] SHALL be high only in IDLE, only for the granted g, combinationally from req_valid; handshake = req_valid[g] & req_ready[g].
REQ-023 On handshake SHALL register op/a/b/shamt of g into alu_sel/alu_a/alu_b/alu_shamt, store g as owner and as last-grant, go to EXEC.
REQ-024 EXEC SHALL last 1 cycle for alu_sel!=100 and MUL_LAT cycles for alu_sel=100, counted by an internal wait counter loaded at handshake.
REQ-025 On the last EXEC cycle SHALL capture alu_result into rsp_result, set rsp_of, rsp_id=owner, go to RESP with rsp_valid=1 from the next cycle.
REQ-026 Latency handshake-edge to rsp_valid high: 2 cycles (non-multiply), MUL_LAT+1 cycles (multiply).
REQ-027 rsp_of SHALL equal alu_of only for alu_sel=010 or 110; 0 for all other codes.
REQ-028 RESP: rsp_valid, rsp_id, rsp_result, rsp_of SHALL hold stable until rsp_ready=1; on that edge rsp_valid drops and FSM returns to IDLE.
REQ-029 No new request SHALL be accepted in EXEC or RESP, including the cycle rsp_ready is sampled; next accept earliest in the following IDLE cycle (min. 3 cycles per op).
REQ-030 alu_a/alu_b/alu_sel/alu_shamt SHALL hold their values through EXEC and RESP and remain unchanged in IDLE until the next handshake.
REQ-031 rsp_ready while rsp_valid=0 SHALL be ignored; req_valid deassertion without handshake SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, req_ready=0 while rst_n=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_of=0, busy=0, alu_a=alu_b=0, alu_sel=000, alu_shamt=0, wait counter=0, last-grant=1 (requester 0 wins first tie).
REQ-033 Reset asserted during EXEC or RESP SHALL abandon the operation with no response produced.

Verification
REQ-034 Requester 0 op=010, a=0x7FFFFFFF, b=1, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_result=0x80000000, rsp_of=1, rsp_id=0.
REQ-035 Both requesters valid continuously, op=000 each, rsp_ready=1 -> grants alternate 0,1,0,1; first grant 0 after reset; no cycle with both req_ready bits high.
REQ-036 Requester 1 op=100, a=3, b=5, MUL_LAT=2 -> rsp_valid 3 cycles after handshake, rsp_result=15, rsp_of=0 regardless of alu_of.
REQ-037 Op=011, a=1, shamt=31, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result=0x80000000 stable all 5 cycles, req_ready stays 00, release on rsp_ready=1.
REQ-038 rst_n pulled low in the single EXEC cycle of op=110 -> busy=0 and rsp_valid=0 asynchronously; no response after reset release; next request granted to requester 0 on tie.
